// File: rtl/gesture_pkg.sv
// Constants shared by the skin-mask pipeline blocks (median filter, segmenter, frame RAM).
package gesture_pkg;
  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  localparam int COL_W        = $clog2(H_ACTIVE_DEF);
  localparam int ROW_W        = $clog2(V_ACTIVE_DEF);
  localparam int AREA_W       = 17;

  function automatic logic [3:0] popcnt9(input logic [8:0] w);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, w[i]};
    return n;
  endfunction
endpackage

// File: rtl/line_buffer_1b.sv
// One-line 1-bit delay: circular RAM, dout is the bit written DEPTH pixels earlier.
module line_buffer_1b #(
  parameter int DEPTH = 320
) (
  input  logic guass_clk,
  input  logic RST_N,
  input  logic din,
  output logic dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          mem [DEPTH];
  logic [PW-1:0] ptr_q;

  // Read-before-write on the same slot gives exactly DEPTH cycles of delay.
  assign dout = mem[ptr_q];

  always_ff @(posedge guass_clk) mem[ptr_q] <= din;

  always_ff @(posedge guass_clk or negedge RST_N) begin
    if (!RST_N)                        ptr_q <= '0;
    else if (ptr_q == PW'(DEPTH - 1))  ptr_q <= '0;
    else                               ptr_q <= ptr_q + 1'b1;
  end
endmodule

// File: rtl/binary_median3x3.sv
// 3x3 binary majority filter on the skin mask, with per-frame white-pixel area.
module binary_median3x3
  import gesture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int THRESH   = 5
) (
  input  logic              guass_clk,
  input  logic              RST_N,
  input  logic              CMOS_VSYNC,
  input  logic              en,
  input  logic              data_in,
  output logic              data_me,
  output logic              frame_done,
  output logic [AREA_W-1:0] area_out
);
  localparam int CW = $clog2(H_ACTIVE);
  localparam int RW = $clog2(V_ACTIVE);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              run_q, run_d;
  logic              cnt_q, last_q;
  logic [AREA_W-1:0] acc_q, acc_d, area_d;
  logic              fd_d, me_d;
  logic              lb0, lb1;
  logic [2:0][1:0]   win_q;
  logic [8:0]        win;
  logic              pix_vld, last_pix, inner, med;

  line_buffer_1b #(.DEPTH(H_ACTIVE)) u_lb0 (
    .guass_clk(guass_clk), .RST_N(RST_N), .din(data_in), .dout(lb0));
  line_buffer_1b #(.DEPTH(H_ACTIVE)) u_lb1 (
    .guass_clk(guass_clk), .RST_N(RST_N), .din(lb0), .dout(lb1));

  // Rows r-2, r-1, r; each row is {col c, col c-1, col c-2}.
  assign win = {lb1, win_q[0], lb0, win_q[1], data_in, win_q[2]};

  // run_q is low after reset and after the last pixel: only VSYNC re-arms the frame.
  assign pix_vld  = run_q & ~CMOS_VSYNC;
  assign last_pix = pix_vld && (col_q == CW'(H_ACTIVE - 1)) && (row_q == RW'(V_ACTIVE - 1));
  assign inner    = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign med      = inner && (int'(popcnt9(win)) >= THRESH);
  assign me_d     = pix_vld & (en ? med : data_in);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    run_d = run_q;
    if (CMOS_VSYNC) begin
      col_d = '0;
      row_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (last_pix) begin
        run_d = 1'b0;
      end else if (col_q == CW'(H_ACTIVE - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Area trails the pixel by one stage so the final data_me is included.
  always_comb begin
    acc_d  = acc_q;
    area_d = area_out;
    fd_d   = 1'b0;
    if (cnt_q) acc_d = acc_q + AREA_W'(data_me);
    if (last_q) begin
      area_d = acc_d;
      fd_d   = 1'b1;
      acc_d  = '0;
    end
    if (CMOS_VSYNC) acc_d = '0;
  end

  always_ff @(posedge guass_clk or negedge RST_N) begin
    if (!RST_N) begin
      col_q      <= '0;
      row_q      <= '0;
      run_q      <= 1'b0;
      cnt_q      <= 1'b0;
      last_q     <= 1'b0;
      acc_q      <= '0;
      area_out   <= '0;
      frame_done <= 1'b0;
      data_me    <= 1'b0;
      win_q      <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      run_q      <= run_d;
      cnt_q      <= pix_vld;
      last_q     <= last_pix;
      acc_q      <= acc_d;
      area_out   <= area_d;
      frame_done <= fd_d;
      data_me    <= me_d;
      win_q[0]   <= {win_q[0][0], lb1};
      win_q[1]   <= {win_q[1][0], lb0};
      win_q[2]   <= {win_q[2][0], data_in};
    end
  end
endmodule
